e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Multiply/divide unit in the Execute stage, upstream of the EX/MEM pipeline register.
//  Runs MIPS mult/multu/div/divu and mthi/mtlo against private HI/LO registers.
//  Models multi-cycle latency with a busy flag that the hazard unit uses to stall D.
//  mfhi/mflo read hiOut/loOut combinationally; E muxes them into the ALU result for M.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd family); legal range 1..15
//  DIV_CYCLES   10  busy cycles for div/divu; legal range 1..15
// PORTS
//  clk      in   1   system clock, all state changes on posedge
//  reset    in   1   synchronous, active-high
//  start    in   1   op valid this cycle (E-stage instr is an MDU op)
//  op       in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                    7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU (7-10 only with MDU_MADD_EN)
//  srcA     in   32  rs operand (forwarded value)
//  srcB     in   32  rt operand (forwarded value)
//  busy     out  1   multi-cycle op in flight
//  hiOut    out  32  current HI register
//  loOut    out  32  current LO register
// BEHAVIOUR
//  Reset: busy=0, hiOut=0, loOut=0, counter=0, pending result cleared; FSM -> IDLE.
//  Reset mid-operation aborts the op; HI/LO take 0, no late commit.
//  FSM: IDLE, RUN.
//   IDLE + start + MULT-family/DIV-family op: latch computed 64-bit result into pendHi/pendLo,
//     load counter with MULT_CYCLES or DIV_CYCLES; -> RUN. busy=1 from next cycle.
//   RUN: counter decrements each cycle; on the edge where counter==1 commit pendHi/pendLo
//     to HI/LO, busy->0, -> IDLE.
//   Latency: start accepted in cycle T -> busy high cycles T+1..T+N -> new HI/LO visible T+N+1.
//  MTHI/MTLO in IDLE: HI<=srcA (or LO<=srcA) at next edge, busy stays 0, single cycle.
//  start while busy (any op): ignored, no state change; hazard unit must stall such ops.
//  Stall condition for hazard unit = busy | (start & op in MULT..DIVU/MADD..MSUBU).
//  op NONE or op>10 (or 7..10 without macro) with start=1: no effect, busy stays 0.
//  Arithmetic: MULT signed 32x32->64, MULTU unsigned; {HI,LO}=product.
//   DIV signed: LO=quotient truncated toward zero, HI=remainder with dividend sign.
//   DIVU unsigned. Divisor==0: op still takes DIV_CYCLES, HI/LO left unchanged.
//   DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
//  hiOut/loOut change only on commit/mthi/mtlo edges; stable during RUN (old values).
// CONFIGURATION
//  MDU_MADD_EN defined: ops 7-10 accepted with MULT_CYCLES latency;
//   MADD/MADDU {HI,LO}+=product, MSUB/MSUBU {HI,LO}-=product; 64-bit wrap;
//   accumulator base is HI/LO sampled at accept cycle.
//  MDU_MADD_EN undefined: ops 7-10 treated as NONE; no accumulate adder synthesized.
// TESTING
//  1) reset, start MULT srcA=-3 srcB=7 -> busy cycles 1..5, then HI=0xFFFFFFFF LO=0xFFFFFFEB.
//  2) MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE LO=0x00000001.
//  3) DIV -7/2 -> 10 busy cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged.
//  4) MTHI 0x1234 then MTLO 0x5678 back-to-back -> HI=0x1234 next edge, LO=0x5678 next; busy=0.
//  5) start DIV, assert start MTLO 0xAA at busy cycle 3, reset at busy cycle 6 -> MTLO ignored;
//     busy=0, HI=LO=0 after reset edge, no commit afterwards.
//  6) MDU_MADD_EN: HI=0 LO=0xFFFFFFFF, MADDU 1*1 -> HI=1 LO=0 after 5 cycles; without macro -> no change.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with private HI/LO and a fixed-latency busy window.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hiOut,
    output logic [31:0] loOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        pend_wr;
    logic [31:0] hi, lo;

    logic        is_mul, is_div, mul_sgn, accept, commit;
    logic [63:0] mul_p, div_r, res;
    logic        res_wr;

    // Full 64-bit product; operands are sign- or zero-extended before multiplying.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] sa, sb;
        sa = {{32{sgn & a[31]}}, a};
        sb = {{32{sgn & b[31]}}, b};
        return sa * sb;
    endfunction

    // Returns {remainder, quotient}. Signed case divides magnitudes, so
    // 0x80000000 / -1 naturally wraps to 0x80000000 with remainder 0.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        an, bn;
        logic [31:0] ua, ub, uq, ur, q, r;
        an = sgn & a[31];
        bn = sgn & b[31];
        ua = an ? 32'(-a) : a;
        ub = bn ? 32'(-b) : b;
        if (ub == 32'd0) begin
            uq = 32'd0;
            ur = 32'd0;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
        end
        q = (an ^ bn) ? 32'(-uq) : uq;
        r = an ? 32'(-ur) : ur;
        return {r, q};
    endfunction

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        mul_sgn = (op == OP_MULT);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU)
                        || (op == OP_MSUB) || (op == OP_MSUBU);
        mul_sgn = mul_sgn || (op == OP_MADD) || (op == OP_MSUB);
`endif
        accept = start && (state == IDLE) && (is_mul || is_div);
    end

    always_comb begin
        mul_p  = mul64(srcA, srcB, mul_sgn);
        div_r  = div64(srcA, srcB, op == OP_DIV);
        res    = mul_p;
        res_wr = 1'b1;
        case (op)
            OP_DIV, OP_DIVU: begin
                res    = div_r;
                res_wr = (srcB != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res = {hi, lo} + mul_p;
            OP_MSUB, OP_MSUBU: res = {hi, lo} - mul_p;
`endif
            default: res = mul_p;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy   = (state == RUN);
        commit = (state == RUN) && (cnt == 4'd1);
    end

    // Counter, pending result and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            if (accept) begin
                cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
                pend    <= res;
                pend_wr <= res_wr;
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                pend_wr <= 1'b0;
                if (pend_wr) begin
                    hi <= pend[63:32];
                    lo <= pend[31:0];
                end
            end
            if (start && (state == IDLE) && (op == OP_MTHI)) hi <= srcA;
            if (start && (state == IDLE) && (op == OP_MTLO)) lo <= srcA;
        end
    end

    assign hiOut = hi;
    assign loOut = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] srcA, srcB;
    logic        busy;
    logic [31:0] hiOut, loOut;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .hiOut(hiOut), .loOut(loOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || busy !== e.busy || hiOut !== e.hi || loOut !== e.lo) begin
                errors++;
                $display("FAIL %s @%0d: got busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h @%0d",
                         e.name, cyc, busy, hiOut, loOut, e.busy, e.hi, e.lo, e.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string nm, input int c, input logic b,
                             input logic [31:0] h, input logic [31:0] l);
        exp_t x;
        x.name = nm; x.cyc = c; x.busy = b; x.hi = h; x.lo = l;
        sb.push_back(x);
    endtask

    task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] oh, input logic [31:0] ol,
                          input logic [31:0] nh, input logic [31:0] nl);
        int t;
        t = cyc;
        start = 1'b1; op = o; srcA = a; srcB = b;
        for (int i = 1; i <= n; i++) expect_at({nm, "_busy"}, t + i, 1'b1, oh, ol);
        expect_at({nm, "_done"}, t + n + 1, 1'b0, nh, nl);
        step(1);
        start = 1'b0; op = 4'd0;
        step(n);
    endtask

    task automatic single(input string nm, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] eh, input logic [31:0] el);
        int t;
        t = cyc;
        start = 1'b1; op = o; srcA = a; srcB = 32'h0;
        expect_at(nm, t + 1, 1'b0, eh, el);
        step(1);
        start = 1'b0; op = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] eh, el;
        int t;
        reset = 1'b1; start = 1'b0; op = 4'd0; srcA = 32'h0; srcB = 32'h0;
        step(2);
        reset = 1'b0;
        expect_at("reset", cyc, 1'b0, 32'h0, 32'h0);

        run_op("mult_m3x7", 4'd1, 32'hFFFFFFFD, 32'd7, 5,
               32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
               32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000001);
        run_op("div_m7_2", 4'd3, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_by0", 4'd4, 32'd7, 32'd0, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_m2", 4'd3, 32'd7, 32'hFFFFFFFE, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10,
               32'h00000001, 32'hFFFFFFFD, 32'h00000000, 32'h80000000);
        run_op("divu_100_7", 4'd4, 32'd100, 32'd7, 10,
               32'h00000000, 32'h80000000, 32'h00000002, 32'h0000000E);

        single("mthi", 4'd5, 32'h1234, 32'h1234, 32'h0000000E);
        single("mtlo", 4'd6, 32'h5678, 32'h1234, 32'h5678);
        single("op_none", 4'd0, 32'hDEAD, 32'h1234, 32'h5678);
        single("op_11", 4'd11, 32'hDEAD, 32'h1234, 32'h5678);
        single("op_15", 4'd15, 32'hDEAD, 32'h1234, 32'h5678);

        run_op("mult_minsq", 4'd1, 32'h80000000, 32'h80000000, 5,
               32'h1234, 32'h5678, 32'h40000000, 32'h0);

        single("mthi_0", 4'd5, 32'h0, 32'h0, 32'h0);
        single("mtlo_ff", 4'd6, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        run_op("maddu_1x1", 4'd8, 32'd1, 32'd1, 5,
               32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
        run_op("msub_m1x1", 4'd9, 32'hFFFFFFFF, 32'd1, 5,
               32'h1, 32'h0, 32'h1, 32'h1);
        eh = 32'h1; el = 32'h1;
`else
        single("maddu_off", 4'd8, 32'd1, 32'h0, 32'hFFFFFFFF);
        single("msub_off", 4'd9, 32'd1, 32'h0, 32'hFFFFFFFF);
        eh = 32'h0; el = 32'hFFFFFFFF;
`endif

        // DIV in flight, MTLO while busy, then reset before commit
        t = cyc;
        start = 1'b1; op = 4'd3; srcA = 32'd20; srcB = 32'd3;
        for (int i = 1; i <= 6; i++) expect_at("abort_busy", t + i, 1'b1, eh, el);
        expect_at("abort_reset", t + 7, 1'b0, 32'h0, 32'h0);
        expect_at("abort_nocommit", t + 12, 1'b0, 32'h0, 32'h0);
        expect_at("abort_after", t + 13, 1'b0, 32'h0, 32'h0);
        step(1);
        start = 1'b0; op = 4'd0;
        step(2);
        start = 1'b1; op = 4'd6; srcA = 32'hAA;
        step(1);
        start = 1'b0; op = 4'd0;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(6);

        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
